// File: rtl/systolic_array_ctrl.sv
// Job sequencer for the N_SIZE x N_SIZE output-stationary systolic multiplier.
// Optional watchdog on WAIT/CAPTURE (adds the err port) when SA_CTRL_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | accept operand row loads and start
// CLEAR   | one cycle with the array held in reset
// FEED    | stream column k of A and row k of B, k = 0..N_SIZE-1
// WAIT    | wait for the first result row from the array
// CAPTURE | collect result rows 0..N_SIZE-1 in arrival order
// DRAIN   | present result rows on the valid/ready stream
module systolic_array_ctrl #(
    parameter int DATAWIDTH = 16,
    parameter int N_SIZE    = 5,
    localparam int IW       = (N_SIZE > 1) ? $clog2(N_SIZE) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_en,
    input  logic                          load_sel,
    input  logic [IW-1:0]                 load_idx,
    input  logic [N_SIZE*DATAWIDTH-1:0]   load_data,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
`ifdef SA_CTRL_TIMEOUT_EN
    output logic                          err,
`endif
    output logic                          sa_rst_n,
    output logic                          sa_valid_in,
    output logic [N_SIZE*DATAWIDTH-1:0]   sa_a_out,
    output logic [N_SIZE*DATAWIDTH-1:0]   sa_b_out,
    input  logic                          sa_valid_out,
    input  logic [N_SIZE*2*DATAWIDTH-1:0] sa_c_in,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [IW-1:0]                 res_row,
    output logic [N_SIZE*2*DATAWIDTH-1:0] res_data
);

    localparam int RW  = N_SIZE * DATAWIDTH;
    localparam int CRW = N_SIZE * 2 * DATAWIDTH;
    localparam logic [IW-1:0] LAST = IW'(N_SIZE - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_WAIT, S_CAPTURE, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    k_q, k_d, r_q, r_d, row_q, row_d;
    logic             clear_q, clear_d, busy_q, busy_d, done_q, done_d;
    logic             vin_q, vin_d, rv_q, rv_d;
    logic [RW-1:0]    a_out_q, a_out_d, b_out_q, b_out_d;
    logic [CRW-1:0]   data_q, data_d;
    logic [RW-1:0]    a_buf_q [N_SIZE];
    logic [RW-1:0]    b_buf_q [N_SIZE];
    logic [CRW-1:0]   c_buf_q [N_SIZE];
    logic             load_we, cap_we;
    logic [IW-1:0]    k_sel, row_nxt;
    logic [RW-1:0]    op_a;

`ifdef SA_CTRL_TIMEOUT_EN
    localparam int WDW = $clog2(4 * N_SIZE);
    logic [WDW-1:0]   wd_q, wd_d;
    logic             err_q, err_d;
`endif

    // Operands for the cycle after this edge: k=0 when leaving CLEAR, k_q+1 inside FEED.
    assign k_sel = (state_q == S_FEED && k_q != LAST) ? k_q + 1'b1 : '0;

    always_comb begin
        op_a = '0;
        for (int i = 0; i < N_SIZE; i++)
            op_a[i*DATAWIDTH +: DATAWIDTH] = a_buf_q[i][int'(k_sel)*DATAWIDTH +: DATAWIDTH];
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        r_d     = r_q;
        row_d   = row_q;
        clear_d = 1'b0;
        done_d  = 1'b0;
        vin_d   = 1'b0;
        a_out_d = '0;
        b_out_d = '0;
        rv_d    = rv_q;
        data_d  = data_q;
        load_we = 1'b0;
        cap_we  = 1'b0;
        row_nxt = row_q + 1'b1;
`ifdef SA_CTRL_TIMEOUT_EN
        wd_d    = wd_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                load_we = load_en && (int'(load_idx) < N_SIZE);
                if (start) begin
                    state_d = S_CLEAR;
                    clear_d = 1'b1;
`ifdef SA_CTRL_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                k_d     = '0;
                vin_d   = 1'b1;
                a_out_d = op_a;
                b_out_d = b_buf_q[k_sel];
            end
            S_FEED: begin
                if (k_q == LAST) begin
                    state_d = S_WAIT;
                    r_d     = '0;
`ifdef SA_CTRL_TIMEOUT_EN
                    wd_d    = WDW'(4 * N_SIZE - 1);
`endif
                end else begin
                    k_d     = k_sel;
                    vin_d   = 1'b1;
                    a_out_d = op_a;
                    b_out_d = b_buf_q[k_sel];
                end
            end
            S_WAIT, S_CAPTURE: begin
                // The first valid row is taken in WAIT so a back-to-back burst loses nothing.
                if (sa_valid_out) begin
                    cap_we  = 1'b1;
                    state_d = S_CAPTURE;
                    if (r_q == LAST) begin
                        state_d = S_DRAIN;
                        rv_d    = 1'b1;
                        row_d   = '0;
                        data_d  = (LAST == '0) ? sa_c_in : c_buf_q[0];
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                end
`ifdef SA_CTRL_TIMEOUT_EN
                if (state_d != S_DRAIN) begin
                    if (wd_q == '0) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        wd_d = wd_q - 1'b1;
                    end
                end
`endif
            end
            S_DRAIN: begin
                if (res_ready) begin
                    if (row_q == LAST) begin
                        state_d = S_IDLE;
                        rv_d    = 1'b0;
                        done_d  = 1'b1;
                        row_d   = '0;
                        data_d  = '0;
                    end else begin
                        row_d  = row_nxt;
                        data_d = c_buf_q[row_nxt];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            r_q     <= '0;
            row_q   <= '0;
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vin_q   <= 1'b0;
            rv_q    <= 1'b0;
            a_out_q <= '0;
            b_out_q <= '0;
            data_q  <= '0;
`ifdef SA_CTRL_TIMEOUT_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            r_q     <= r_d;
            row_q   <= row_d;
            clear_q <= clear_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vin_q   <= vin_d;
            rv_q    <= rv_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
            data_q  <= data_d;
`ifdef SA_CTRL_TIMEOUT_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SIZE; i++) begin
                a_buf_q[i] <= '0;
                b_buf_q[i] <= '0;
                c_buf_q[i] <= '0;
            end
        end else begin
            if (load_we && !load_sel) a_buf_q[load_idx] <= load_data;
            if (load_we && load_sel)  b_buf_q[load_idx] <= load_data;
            if (cap_we)               c_buf_q[r_q]      <= sa_c_in;
        end
    end

    assign sa_rst_n    = rst_n & ~clear_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sa_valid_in = vin_q;
    assign sa_a_out    = a_out_q;
    assign sa_b_out    = b_out_q;
    assign res_valid   = rv_q;
    assign res_row     = row_q;
    assign res_data    = data_q;
`ifdef SA_CTRL_TIMEOUT_EN
    assign err         = err_q;
`endif

endmodule
